// File: rtl/flash_prefetch.sv
// Sequential instruction prefetcher: walks word addresses from the fetch PC, reads flash one word
// at a time, and queues {pc, word} pairs for the core behind a valid/ready handshake.
module flash_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned WAIT     = 0,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        XCLK,
   input  logic        XRES,
   input  logic        REDIR,
   input  logic [31:0] REDIR_PC,
   output logic        IVALID,
   input  logic        IREADY,
   output logic [31:0] IDATA,
   output logic [31:0] IPC,
   output logic        F_EN,
   output logic        F_RE,
   output logic [31:0] F_ADDR,
   input  logic [31:0] F_DATA,
   input  logic        F_GNT
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned WW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
   localparam logic [WW-1:0] WaitLast = WW'(WAIT);
   localparam logic [CW-1:0] Full     = CW'(DEPTH);

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e         state_q, state_d;
   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [WW-1:0]  wcnt_q, wcnt_d;
   logic [CW-1:0]  count_q, count_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [31:0]    ipc_q, ipc_d;
   logic [31:0]    idata_q, idata_d;
   logic [31:0]    mem_pc_q   [DEPTH];
   logic [31:0]    mem_data_q [DEPTH];
   logic           pop, push;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      wcnt_d     = wcnt_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      ipc_d      = ipc_q;
      idata_d    = idata_q;
      pop        = 1'b0;
      push       = 1'b0;

      if (REDIR) begin
         // The flushed queue always has room, so the new PC is requested straight away.
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         wcnt_d     = '0;
         fetch_pc_d = {REDIR_PC[31:2], 2'b00};
         state_d    = F_GNT ? StReq : StIdle;
      end else begin
         pop  = (count_q != '0) && IREADY;
         push = (state_q == StReq) && F_GNT && (wcnt_q == WaitLast);
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         count_d = count_q + CW'(push) - CW'(pop);

         case (state_q)
            StIdle: begin
               if (F_GNT && ((count_q < Full) || pop)) state_d = StReq;
            end
            StReq: begin
               if (!F_GNT) begin
                  state_d = StIdle;
                  wcnt_d  = '0;
               end else if (wcnt_q == WaitLast) begin
                  wcnt_d = '0;
                  if (count_d == Full) state_d = StIdle;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase

         // Head registers track the next head; the pushed word bypasses an empty queue.
         if (count_d != '0) begin
            if (push && (count_q == CW'(pop))) begin
               ipc_d   = fetch_pc_q;
               idata_d = F_DATA;
            end else begin
               ipc_d   = mem_pc_q[rd_ptr_d];
               idata_d = mem_data_q[rd_ptr_d];
            end
         end
      end
   end

   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         wcnt_q     <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         ipc_q      <= '0;
         idata_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]   <= '0;
            mem_data_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         wcnt_q     <= wcnt_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         ipc_q      <= ipc_d;
         idata_q    <= idata_d;
         if (push) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
            mem_data_q[wr_ptr_q] <= F_DATA;
         end
      end
   end

   assign IVALID = (count_q != '0);
   assign IPC    = ipc_q;
   assign IDATA  = idata_q;
   assign F_EN   = (state_q == StReq);
   assign F_RE   = F_EN;
   assign F_ADDR = F_EN ? fetch_pc_q : 32'h0;

endmodule

// File: tb/tb_flash_prefetch.sv
// Bench for flash_prefetch: directed vector table, hand-written wait/reset sequences and a
// randomized run checked against a queue-level model of the prefetch stream.
module tb_flash_prefetch;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        xres, redir, iready, gnt;
   logic [31:0] rpc;

   logic        iv0, fen0, fre0, iv2, fen2, fre2, iv3, fen3, fre3;
   logic [31:0] ipc0, id0, fa0, fd0, ipc2, id2, fa2, fd2, ipc3, id3, fa3, fd3;

   always #5 clk = ~clk;

   // Flash contents: word i holds i*3.
   function automatic logic [31:0] flash_word(input logic [31:0] a);
      return (a >> 2) * 32'd3;
   endfunction

   assign fd0 = flash_word(fa0);
   assign fd2 = flash_word(fa2);
   assign fd3 = flash_word(fa3);

   flash_prefetch #(.DEPTH(DEPTH), .WAIT(0), .RESET_PC(32'h0)) u_w0 (
      .XCLK(clk), .XRES(xres), .REDIR(redir), .REDIR_PC(rpc), .IVALID(iv0), .IREADY(iready),
      .IDATA(id0), .IPC(ipc0), .F_EN(fen0), .F_RE(fre0), .F_ADDR(fa0), .F_DATA(fd0), .F_GNT(gnt));

   flash_prefetch #(.DEPTH(DEPTH), .WAIT(2), .RESET_PC(32'h0)) u_w2 (
      .XCLK(clk), .XRES(xres), .REDIR(redir), .REDIR_PC(rpc), .IVALID(iv2), .IREADY(iready),
      .IDATA(id2), .IPC(ipc2), .F_EN(fen2), .F_RE(fre2), .F_ADDR(fa2), .F_DATA(fd2), .F_GNT(gnt));

   flash_prefetch #(.DEPTH(DEPTH), .WAIT(3), .RESET_PC(32'h40)) u_w3 (
      .XCLK(clk), .XRES(xres), .REDIR(redir), .REDIR_PC(rpc), .IVALID(iv3), .IREADY(iready),
      .IDATA(id3), .IPC(ipc3), .F_EN(fen3), .F_RE(fre3), .F_ADDR(fa3), .F_DATA(fd3), .F_GNT(gnt));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Queue-level model of the WAIT=0 instance plus an in-order stream check of the WAIT=2 one.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_fetch;
   logic [31:0] m_exp2;
   int          m_pops;

   task automatic model_reset(input logic [31:0] pc0);
      mq.delete();
      m_fetch = pc0;
      m_exp2  = pc0;
   endtask

   task automatic step();
      chk("w0 ivalid", 32'(iv0), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("w0 ipc", ipc0, mq[0].pc);
         chk("w0 idata", id0, mq[0].data);
      end
      chk("w0 f_re", 32'(fre0), 32'(fen0));
      if (fen0) chk("w0 f_addr", fa0, m_fetch);
      else      chk("w0 f_addr idle", fa0, 32'h0);
      if (iv2 && iready && !redir) begin
         chk("w2 ipc order", ipc2, m_exp2);
         chk("w2 idata", id2, flash_word(m_exp2));
         m_exp2 = m_exp2 + 32'd4;
      end
      if (redir) begin
         mq.delete();
         m_fetch = {rpc[31:2], 2'b00};
         m_exp2  = {rpc[31:2], 2'b00};
      end else begin
         if (mq.size() != 0 && iready) begin
            void'(mq.pop_front());
            m_pops++;
         end
         if (fen0 && gnt) begin
            mq.push_back('{pc: m_fetch, data: flash_word(m_fetch)});
            m_fetch = m_fetch + 32'd4;
         end
         chk("w0 depth", 32'(mq.size() <= DEPTH), 32'd1);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      redir  = 1'b0;
      iready = 1'b0;
      gnt    = 1'b1;
      rpc    = 32'h0;
      xres   = 1'b0;
      #1;
      chk("rst ivalid", 32'(iv0), 32'd0);
      chk("rst ipc", ipc0, 32'h0);
      chk("rst idata", id0, 32'h0);
      chk("rst f_en", 32'(fen0), 32'd0);
      chk("rst f_addr", fa0, 32'h0);
      @(posedge clk);
      #2;
      xres = 1'b1;
      model_reset(32'h0);
   endtask

   typedef struct {
      bit          rst;
      bit          redir;
      logic [31:0] rpc;
      bit          ir;
      bit          iv;
      logic [31:0] ipc;
      logic [31:0] id;
      bit          fen;
      logic [31:0] fa;
   } vec_t;

   vec_t tbl[$];

   task automatic row(input bit rs, input bit rd, input logic [31:0] rp, input bit ir, input bit iv,
                      input logic [31:0] ipc, input bit fen, input logic [31:0] fa);
      tbl.push_back('{rst: rs, redir: rd, rpc: rp, ir: ir, iv: iv, ipc: ipc,
                      id: flash_word(ipc), fen: fen, fa: fa});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      xres   = 1'b1;
      redir  = 1'b0;
      iready = 1'b0;
      gnt    = 1'b1;
      rpc    = 32'h0;
      m_pops = 0;
      model_reset(32'h0);

      // Streaming from reset, one word per cycle.
      row(1, 0, 0, 1, 0, 32'h0,  0, 32'h0);
      row(0, 0, 0, 1, 0, 32'h0,  1, 32'h0);
      row(0, 0, 0, 1, 1, 32'h0,  1, 32'h4);
      row(0, 0, 0, 1, 1, 32'h4,  1, 32'h8);
      row(0, 0, 0, 1, 1, 32'h8,  1, 32'hC);
      // Backpressure: four pushes fill the queue, one pop allows one more request.
      row(1, 0, 0, 0, 0, 32'h0,  0, 32'h0);
      row(0, 0, 0, 0, 0, 32'h0,  1, 32'h0);
      row(0, 0, 0, 0, 1, 32'h0,  1, 32'h4);
      row(0, 0, 0, 0, 1, 32'h0,  1, 32'h8);
      row(0, 0, 0, 0, 1, 32'h0,  1, 32'hC);
      row(0, 0, 0, 0, 1, 32'h0,  0, 32'h0);
      row(0, 0, 0, 1, 1, 32'h0,  0, 32'h0);
      row(0, 0, 0, 0, 1, 32'h4,  1, 32'h10);
      row(0, 0, 0, 0, 1, 32'h4,  0, 32'h0);
      // Redirect during push+pop with misaligned PC, then redirect across the address wrap.
      row(1, 0, 0, 1, 0, 32'h0,  0, 32'h0);
      row(0, 0, 0, 1, 0, 32'h0,  1, 32'h0);
      row(0, 0, 0, 1, 1, 32'h0,  1, 32'h4);
      row(0, 1, 32'h103, 1, 1, 32'h4, 1, 32'h8);
      row(0, 0, 0, 1, 0, 32'h4,  1, 32'h100);
      row(0, 0, 0, 1, 1, 32'h100, 1, 32'h104);
      row(0, 1, 32'hFFFF_FFF8, 1, 1, 32'h104, 1, 32'h108);
      row(0, 0, 0, 1, 0, 32'h104, 1, 32'hFFFF_FFF8);
      row(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC);
      row(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'h0);
      row(0, 0, 0, 1, 1, 32'h0, 1, 32'h4);

      #3;
      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         redir  = tbl[i].redir;
         rpc    = tbl[i].rpc;
         iready = tbl[i].ir;
         gnt    = 1'b1;
         chk($sformatf("tbl[%0d] ivalid", i), 32'(iv0), 32'(tbl[i].iv));
         chk($sformatf("tbl[%0d] ipc", i), ipc0, tbl[i].ipc);
         chk($sformatf("tbl[%0d] idata", i), id0, tbl[i].id);
         chk($sformatf("tbl[%0d] f_en", i), 32'(fen0), 32'(tbl[i].fen));
         chk($sformatf("tbl[%0d] f_addr", i), fa0, tbl[i].fa);
         step();
      end
      redir = 1'b0;

      // WAIT=2: grant lost in the second wait cycle of 0x20, then a fresh full read.
      do_reset();
      iready = 1'b1;
      n = 0;
      while (!(fen2 && fa2 == 32'h20) && n < 200) begin
         step();
         n++;
      end
      chk("w2 reach 0x20", 32'(fen2 && fa2 == 32'h20), 32'd1);
      step();
      step();
      gnt = 1'b0;
      chk("w2 f_en before drop", 32'(fen2), 32'd1);
      step();
      chk("w2 f_en dropped", 32'(fen2), 32'd0);
      chk("w2 no push", 32'(iv2), 32'd0);
      step();
      chk("w2 f_en idle", 32'(fen2), 32'd0);
      gnt = 1'b1;
      step();
      n = 0;
      while (fen2 && fa2 == 32'h20 && n < 10) begin
         step();
         n++;
      end
      chk("w2 retry length", 32'(n), 32'd3);
      chk("w2 retry ivalid", 32'(iv2), 32'd1);
      chk("w2 retry ipc", ipc2, 32'h20);
      chk("w2 next addr", fa2, 32'h24);
      for (int i = 0; i < 12; i++) step();

      // WAIT=3: reset asserted in the middle of a read.
      do_reset();
      n = 0;
      while (!iv3 && n < 20) begin
         step();
         n++;
      end
      chk("w3 first ipc", ipc3, 32'h40);
      chk("w3 first idata", id3, flash_word(32'h40));
      step();
      chk("w3 mid-read f_en", 32'(fen3), 32'd1);
      #2;
      xres = 1'b0;
      #1;
      chk("w3 async f_en", 32'(fen3), 32'd0);
      chk("w3 async ivalid", 32'(iv3), 32'd0);
      chk("w3 async ipc", ipc3, 32'h0);
      chk("w3 async f_addr", fa3, 32'h0);
      model_reset(32'h0);
      @(posedge clk);
      #2;
      xres = 1'b1;
      chk("w3 release idle", 32'(fen3), 32'd0);
      step();
      chk("w3 restart f_en", 32'(fen3), 32'd1);
      chk("w3 restart addr", fa3, 32'h40);

      // Randomized traffic: redirects, grant loss and backpressure.
      do_reset();
      m_pops = 0;
      for (int i = 0; i < 3000; i++) begin
         redir  = ($urandom_range(0, 31) == 0);
         rpc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
         iready = ($urandom_range(0, 3) != 0);
         gnt    = ($urandom_range(0, 7) != 0);
         step();
      end
      redir = 1'b0;
      chk("random progress", 32'(m_pops > 300), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
